// File: rtl/stages_definition_pkg.sv
// Shared pipeline-stage types: fetch FSM encoding and the fetch/decode hand-off record.
package stages_definition_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            valid;
    } fetch_decode_interface;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
interface fetch_stage_if #(
    parameter int unsigned N = 32
);

    logic         imemReq;
    logic [N-1:0] imemAddr;
    logic         imemAck;
    logic [N-1:0] imemData;

    modport master (
        output imemReq,
        output imemAddr,
        input  imemAck,
        input  imemData
    );

    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemAck,
        output imemData
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// fetchPC register with +4 incrementer and branch redirect mux; exposes current and next value.
module fetch_pc_reg #(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(32'h0000_0000)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance_i,
    input  logic         redirect_i,
    input  logic [N-1:0] target_i,
    output logic [N-1:0] pc_o,
    output logic [N-1:0] pc_next_o
);

    localparam logic [N-1:0] STEP       = N'(32'd4);
    localparam logic [N-1:0] ALIGN_MASK = ~N'(32'd3);

    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;

    // Redirect wins over sequential advance; targets are forced word-aligned.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & ALIGN_MASK;
        end else if (advance_i) begin
            pc_d = pc_q + STEP;
        end else begin
            pc_d = pc_q;
        end
    end

    // fetchPC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request FSM, one-entry skid buffer and the F/D pipeline register.
// Request outputs are registered from next-state so imemAddr never glitches mid-request.
module fetch_stage
    import stages_definition_pkg::*;
#(
    parameter int unsigned  N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(32'h0000_0000)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          branch,
    input  logic [N-1:0]  branchTarget,
    fetch_stage_if.master imem,
    output logic [N-1:0]  inst,
    output logic [N-1:0]  pc,
    output logic          instValid
);

    localparam logic [N-1:0] PC_OFFSET = N'(32'd8);
    localparam logic [N-1:0] ZERO_W    = {N{1'b0}};

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic         req_q;
    logic         req_d;
    logic [N-1:0] addr_q;
    logic [N-1:0] addr_d;

    logic [N-1:0] fd_inst_q;
    logic [N-1:0] fd_inst_d;
    logic [N-1:0] fd_pc_q;
    logic [N-1:0] fd_pc_d;
    logic         fd_valid_q;
    logic         fd_valid_d;

    logic [N-1:0] skid_inst_q;
    logic [N-1:0] skid_inst_d;
    logic [N-1:0] skid_pc_q;
    logic [N-1:0] skid_pc_d;

    logic         ack_s;
    logic [N-1:0] data_s;
    logic         pc_advance_s;
    logic [N-1:0] fetch_pc_s;
    logic [N-1:0] fetch_pc_next_s;

    assign ack_s  = imem.imemAck;
    assign data_s = imem.imemData;

    // Any response taken in REQ consumes its address, even if it is then discarded by flush.
    assign pc_advance_s = (state_q == REQ) && ack_s && !branch;

    fetch_pc_reg #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .advance_i  (pc_advance_s),
        .redirect_i (branch),
        .target_i   (branchTarget),
        .pc_o       (fetch_pc_s),
        .pc_next_o  (fetch_pc_next_s)
    );

    // Next-state, skid buffer and F/D register logic.
    always_comb begin
        state_d     = state_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        fd_inst_d   = fd_inst_q;
        fd_pc_d     = fd_pc_q;
        fd_valid_d  = fd_valid_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (branch) begin
                    state_d = ack_s ? REQ : DROP;
                end else if (ack_s && stall && !flush) begin
                    state_d     = HOLD;
                    skid_inst_d = data_s;
                    skid_pc_d   = fetch_pc_s + PC_OFFSET;
                end else begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (branch) begin
                    state_d     = REQ;
                    skid_inst_d = ZERO_W;
                    skid_pc_d   = ZERO_W;
                end else if (!stall) begin
                    state_d = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            DROP: begin
                state_d = ack_s ? REQ : DROP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // F/D priority: branch/flush bubble, then stall hold, then new instruction, else bubble.
        if (branch || flush) begin
            fd_inst_d  = ZERO_W;
            fd_pc_d    = ZERO_W;
            fd_valid_d = 1'b0;
        end else if (stall) begin
            fd_inst_d  = fd_inst_q;
            fd_pc_d    = fd_pc_q;
            fd_valid_d = fd_valid_q;
        end else if ((state_q == REQ) && ack_s) begin
            fd_inst_d  = data_s;
            fd_pc_d    = fetch_pc_s + PC_OFFSET;
            fd_valid_d = 1'b1;
        end else if (state_q == HOLD) begin
            fd_inst_d  = skid_inst_q;
            fd_pc_d    = skid_pc_q;
            fd_valid_d = 1'b1;
        end else begin
            fd_inst_d  = ZERO_W;
            fd_pc_d    = ZERO_W;
            fd_valid_d = 1'b0;
        end

        // DROP keeps presenting the abandoned address until memory answers it.
        req_d = (state_d == REQ) || (state_d == DROP);
        if (state_d == DROP) begin
            addr_d = addr_q;
        end else begin
            addr_d = fetch_pc_next_s;
        end
    end

    // FSM, request outputs, skid buffer and F/D register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            fd_inst_q   <= ZERO_W;
            fd_pc_q     <= ZERO_W;
            fd_valid_q  <= 1'b0;
            skid_inst_q <= ZERO_W;
            skid_pc_q   <= ZERO_W;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            fd_inst_q   <= fd_inst_d;
            fd_pc_q     <= fd_pc_d;
            fd_valid_q  <= fd_valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign imem.imemReq  = req_q;
    assign imem.imemAddr = addr_q;
    assign inst          = fd_inst_q;
    assign pc            = fd_pc_q;
    assign instValid     = fd_valid_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter N, default 32: instruction and address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  hold PC and F/D outputs this cycle.
REQ-006 flush  in  1  invalidate F/D outputs next cycle (bubble).
REQ-007 branch  in  1  redirect fetch to branchTarget.
REQ-008 branchTarget  in  N  redirect address, word-aligned.
REQ-009 imemReq  out  1  instruction-memory request.
REQ-010 imemAddr  out  N  request address; stable while imemReq high and no imemAck.
REQ-011 imemAck  in  1  response valid; imemData sampled same cycle.
REQ-012 imemData  in  N  instruction word.
REQ-013 inst  out  N  F/D instruction to decode; 0 when instValid low.
REQ-014 pc  out  N  F/D value: fetch address of inst + 8 (R15 read value for decode).
REQ-015 instValid  out  1  F/D register holds a live instruction.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD, DROP; IDLE entered on reset, IDLE -> REQ unconditionally next cycle.
REQ-017 REQ: imemReq=1, imemAddr=fetchPC; no ack -> stay REQ.
REQ-018 REQ, ack, !stall, !branch, !flush: F/D <= {imemData, fetchPC+8, valid=1}; fetchPC += 4; stay REQ (one instruction per cycle at zero-wait memory).
REQ-019 REQ, ack, stall, !branch: imemData captured in one-entry skid buffer, F/D unchanged, fetchPC += 4, -> HOLD.
REQ-020 HOLD: imemReq=0; on !stall skid -> F/D (valid=1), -> REQ.
REQ-021 Branch in REQ with ack: response discarded, fetchPC <= branchTarget, stay REQ.
REQ-022 Branch in REQ without ack: fetchPC <= branchTarget, -> DROP; imemAddr keeps old address.
REQ-023 DROP: imemReq=1 on old address; on ack data discarded, -> REQ at branchTarget; further branches in DROP overwrite fetchPC.
REQ-024 Branch in HOLD: skid discarded, fetchPC <= branchTarget, -> REQ.
REQ-025 Branch SHALL clear instValid next cycle regardless of stall.
REQ-026 Flush SHALL clear instValid next cycle; flush overrides stall; flush without branch does not alter fetchPC or FSM; an instruction arriving same cycle as flush is discarded and fetchPC still advances.
REQ-027 Priority: rst_n > branch > flush > stall > normal advance.
REQ-028 stall with instValid high SHALL hold inst, pc, instValid unchanged.
REQ-029 fetchPC arithmetic modulo 2^N; 32'hFFFF_FFFC + 4 wraps to 0; pc = addr + 8 wraps likewise.
REQ-030 branchTarget[1:0] ignored (forced 00).

Reset
REQ-031 rst_n low, asynchronously: state=IDLE, fetchPC=RESET_PC, imemReq=0, imemAddr=RESET_PC, inst=0, pc=0, instValid=0, skid cleared.
REQ-032 Reset mid-request: outstanding request abandoned; memory returns to idle on observing imemReq=0.

Structure
REQ-033 fetch_state_t enum and fetch_decode_interface struct {inst, pc, valid} SHALL live in stages_definition_pkg.
REQ-034 One sub-module fetch_pc_reg (fetchPC register, +4 incrementer, redirect mux) SHALL be instantiated; FSM, skid, F/D register in fetch_stage.

Verification
REQ-035 Reset release, imemAck tied 1, imemData = address -> instValid rises cycle 2; inst 0,4,8 on consecutive cycles with pc 8,12,16.
REQ-036 imemAck delayed 3 cycles at addr 0x10 -> imemAddr held 0x10 for 3 cycles, instValid low until ack, then inst=0x10, pc=0x18.
REQ-037 stall asserted same cycle as ack for 0x20, held 2 cycles -> F/D unchanged, then inst=0x20 loaded, fetch resumes 0x24.
REQ-038 branch to 0x100 while request 0x40 pending (no ack) -> DROP; ack for 0x40 discarded; next imemAddr=0x100; instValid never carries 0x40.
REQ-039 stall and flush together -> instValid=0 next cycle; branch+flush+stall together -> fetch redirected, instValid=0.
REQ-040 RESET_PC=32'hFFFF_FFF8, zero-wait -> addresses FFFF_FFF8, FFFF_FFFC, 0; rst_n pulsed mid-stream -> all outputs to reset values within same cycle.
